seq_divider: RTL and testbench

//  Multi-cycle restoring divider; the inverse of the 4-bit add/sub/shift-multiply datapath.

---
 rtl/arith_pkg.sv | 8 +
 rtl/div_step.sv | 18 +
 rtl/seq_divider.sv | 76 +++++++
 tb/tb_seq_divider.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM states, default operand width and counter sizing for the arithmetic blocks
package arith_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEF_WIDTH = 4;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] rs, diff;
  logic ge;
  assign rs = {r, q[WIDTH-1]};
  assign diff = rs - {1'b0, y};
  assign ge = !diff[WIDTH];
  assign r_next = ge ? diff[WIDTH-1:0] : rs[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ge};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider with start/done handshake; SIGNED_DIV_EN selects two's-complement operands
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] out,
  output logic               div_by_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] r, q, yr, r_n, q_n, xm, ym, qf, rf;
  logic [CW-1:0] cnt;
  logic acc, last, yz;
  assign yz = Y == '0;
  assign acc = start && state != CALC;
  assign last = state == CALC && cnt == CW'(WIDTH - 1);
  assign out = {remainder, quotient};
  div_step #(.WIDTH(WIDTH)) u_step (.r(r), .q(q), .y(yr), .r_next(r_n), .q_next(q_n));
`ifdef SIGNED_DIV_EN
  logic sx, sy;
  assign xm = X[WIDTH-1] ? -X : X;
  assign ym = Y[WIDTH-1] ? -Y : Y;
  assign qf = (sx ^ sy) ? -q_n : q_n;
  assign rf = sx ? -r_n : r_n;
  always_ff @(posedge clk)
    if (!rst_n) {sx, sy} <= '0;
    else if (acc) {sx, sy} <= {X[WIDTH-1], Y[WIDTH-1]};
`else
  assign xm = X;
  assign ym = Y;
  assign qf = q_n;
  assign rf = r_n;
`endif
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = acc ? (yz ? DONE : CALC) : state == CALC ? (last ? DONE : CALC) : IDLE;
  always_comb begin
    busy = state == CALC;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      {r, q, yr, cnt} <= '0;
      {quotient, remainder, div_by_zero} <= '0;
    end else if (acc) begin
      r <= '0;
      q <= xm;
      yr <= ym;
      cnt <= '0;
      div_by_zero <= yz;
      if (yz) begin
        quotient <= '1;
        remainder <= X;
      end
    end else if (state == CALC) begin
      r <= r_n;
      q <= q_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        quotient <= qf;
        remainder <= rf;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an integer-arithmetic reference
module tb_seq_divider;
  localparam int W = 4;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] X = '0, Y = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [2*W-1:0] out;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .out(out), .div_by_zero(div_by_zero)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void model(input logic [W-1:0] x, y, output logic [W-1:0] eq, er, output logic ez);
    int a, b, qi, ri;
`ifdef SIGNED_DIV_EN
    a = $signed(x);
    b = $signed(y);
`else
    a = int'(x);
    b = int'(y);
`endif
    if (b == 0) begin
      eq = '1;
      er = x;
      ez = 1;
    end else begin
      qi = a / b;
      ri = a % b;
      eq = qi[W-1:0];
      er = ri[W-1:0];
      ez = 0;
    end
  endfunction

  task automatic run_op(input logic [W-1:0] x, y, output int lat, nb,
                        output logic [W-1:0] q, r, output logic [2*W-1:0] o,
                        output logic z, d2, output logic [W-1:0] qh);
    @(negedge clk);
    X = x; Y = y; start = 1;
    @(negedge clk);
    start = 0;
    lat = 0; nb = 0;
    while (!done && lat < 64) begin
      if (busy) nb++;
      lat++;
      @(negedge clk);
    end
    lat++;
    q = quotient; r = remainder; o = out; z = div_by_zero;
    @(negedge clk);
    d2 = done; qh = quotient;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, quotient, remainder, out, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset: got busy=%b done=%b q=%h r=%h out=%h z=%b, want all 0",
               busy, done, quotient, remainder, out, div_by_zero);
    end
    rst_n = 1;
  endtask

  task automatic test_directed();
    logic [W-1:0] xs[5] = '{4'd13, 4'd15, 4'd2, 4'd7, 4'd6};
    logic [W-1:0] ys[5] = '{4'd3, 4'd1, 4'd9, 4'd0, 4'd4};
    int lat, nb, el, enb;
    logic [W-1:0] q, r, qh, eq, er;
    logic [2*W-1:0] o;
    logic z, d2, ez;
    for (int i = 0; i < 5; i++) begin
      run_op(xs[i], ys[i], lat, nb, q, r, o, z, d2, qh);
      model(xs[i], ys[i], eq, er, ez);
      el = ys[i] == 0 ? 1 : W + 1;
      enb = ys[i] == 0 ? 0 : W;
      total++;
      if (lat !== el || nb !== enb) begin
        bad++;
        $display("FAIL dir_timing %0d/%0d: got lat=%0d busy=%0d, want lat=%0d busy=%0d", xs[i], ys[i], lat, nb, el, enb);
      end
      total++;
      if ({q, r, o, z} !== {eq, er, er, eq, ez}) begin
        bad++;
        $display("FAIL dir_result %0d/%0d: got q=%h r=%h out=%h z=%b, want q=%h r=%h z=%b", xs[i], ys[i], q, r, o, z, eq, er, ez);
      end
      total++;
      if ({d2, qh} !== {1'b0, eq}) begin
        bad++;
        $display("FAIL dir_pulse_hold %0d/%0d: got done_next=%b q_next=%h, want 0 %h", xs[i], ys[i], d2, qh, eq);
      end
`ifndef SIGNED_DIV_EN
      if (i == 0) begin
        total++;
        if (o !== 8'h14) begin
          bad++;
          $display("FAIL dir_13_3_out: got %h want 14", o);
        end
      end
`endif
    end
  endtask

  task automatic test_ignore_busy();
    int c;
    logic [W-1:0] eq, er;
    logic ez;
    model(4'd13, 4'd3, eq, er, ez);
    @(negedge clk);
    X = 13; Y = 3; start = 1;
    @(negedge clk);
    start = 0; c = 1;
    @(negedge clk);
    c++;
    X = 9; Y = 2; start = 1;
    @(negedge clk);
    c++;
    start = 0; X = 0; Y = 0;
    while (!done && c < 64) begin
      @(negedge clk);
      c++;
    end
    total++;
    if ({c, quotient, remainder} !== {W + 1, eq, er}) begin
      bad++;
      $display("FAIL ignore_busy: got lat=%0d q=%h r=%h, want lat=%0d q=%h r=%h", c, quotient, remainder, W + 1, eq, er);
    end
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL ignore_busy_noqueue: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    logic [W-1:0] eq, er, eq2, er2;
    logic ez;
    model(4'd13, 4'd3, eq, er, ez);
    model(4'd6, 4'd4, eq2, er2, ez);
    @(negedge clk);
    X = 13; Y = 3; start = 1;
    @(negedge clk);
    start = 0; c = 1;
    while (!done && c < 64) begin
      @(negedge clk);
      c++;
    end
    total++;
    if ({c, quotient, remainder} !== {W + 1, eq, er}) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d q=%h r=%h, want lat=%0d q=%h r=%h", c, quotient, remainder, W + 1, eq, er);
    end
    X = 6; Y = 4; start = 1;
    @(negedge clk);
    start = 0; c = 1;
    total++;
    if ({busy, done, quotient} !== {2'b10, eq}) begin
      bad++;
      $display("FAIL b2b_nogap: got busy=%b done=%b q=%h, want 1 0 %h", busy, done, quotient, eq);
    end
    while (!done && c < 64) begin
      @(negedge clk);
      c++;
    end
    total++;
    if ({c, quotient, remainder, div_by_zero} !== {W + 1, eq2, er2, 1'b0}) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d q=%h r=%h z=%b, want lat=%0d q=%h r=%h z=0", c, quotient, remainder, div_by_zero, W + 1, eq2, er2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, nb, seen;
    logic [W-1:0] q, r, qh, eq, er;
    logic [2*W-1:0] o;
    logic z, d2, ez;
    run_op(4'd7, 4'd0, lat, nb, q, r, o, z, d2, qh);
    X = 13; Y = 3; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    total++;
    if ({busy, done, quotient, remainder, out, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL abort_reset: got busy=%b done=%b q=%h r=%h out=%h z=%b, want all 0",
               busy, done, quotient, remainder, out, div_by_zero);
    end
    rst_n = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_nodone: got %0d done pulses, want 0", seen);
    end
    run_op(4'd6, 4'd4, lat, nb, q, r, o, z, d2, qh);
    model(4'd6, 4'd4, eq, er, ez);
    total++;
    if ({lat, q, r, z} !== {W + 1, eq, er, ez}) begin
      bad++;
      $display("FAIL abort_fresh: got lat=%0d q=%h r=%h z=%b, want lat=%0d q=%h r=%h z=%b", lat, q, r, z, W + 1, eq, er, ez);
    end
  endtask

  task automatic test_random();
    int lat, nb, el, enb;
    logic [W-1:0] x, y, q, r, qh, eq, er;
    logic [2*W-1:0] o;
    logic z, d2, ez;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom_range(0, 15));
      y = (i % 8 == 0) ? '0 : W'($urandom_range(0, 15));
      run_op(x, y, lat, nb, q, r, o, z, d2, qh);
      model(x, y, eq, er, ez);
      el = y == 0 ? 1 : W + 1;
      enb = y == 0 ? 0 : W;
      total++;
      if ({lat, nb, q, r, o, z, d2, qh} !== {el, enb, eq, er, er, eq, ez, 1'b0, eq}) begin
        bad++;
        $display("FAIL rand %h/%h: got lat=%0d busy=%0d q=%h r=%h out=%h z=%b dn=%b qh=%h, want lat=%0d busy=%0d q=%h r=%h z=%b",
                 x, y, lat, nb, q, r, o, z, d2, qh, el, enb, eq, er, ez);
      end
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    int lat, nb;
    logic [W-1:0] q, r, qh;
    logic [2*W-1:0] o;
    logic z, d2;
    run_op(4'h9, 4'h2, lat, nb, q, r, o, z, d2, qh);
    total++;
    if ({q, r} !== 8'hDF) begin
      bad++;
      $display("FAIL signed_m7_2: got q=%h r=%h, want D F", q, r);
    end
    run_op(4'h8, 4'hF, lat, nb, q, r, o, z, d2, qh);
    total++;
    if ({q, r} !== 8'h80) begin
      bad++;
      $display("FAIL signed_m8_m1: got q=%h r=%h, want 8 0", q, r);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
